// File: rtl/mult_pkg.sv
// Shared types and Booth opcode helpers for the sequential multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] BOOTH_NOP = 2'b00;
   localparam logic [1:0] BOOTH_ADD = 2'b01;
   localparam logic [1:0] BOOTH_SUB = 2'b10;

   // Unsigned mode only ever adds, on the multiplier LSB.
   // Signed mode decodes the radix-2 Booth pair {Q[0], Q_1}.
   function automatic logic [1:0] booth_op(input logic signed_op,
                                           input logic q0,
                                           input logic q_1);
      logic [1:0] op;
      op = BOOTH_NOP;
      if (!signed_op) begin
         if (q0) op = BOOTH_ADD;
      end else begin
         case ({q0, q_1})
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
         endcase
      end
      return op;
   endfunction

endpackage

// File: rtl/sumador_restador.sv
// Combinational adder/subtractor; sub=1 computes a-b via inverted b plus carry-in.
module sumador_restador #(
   parameter int W = 9
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] s
);

   // Carry out is dropped: the guard bit upstream keeps results in range.
   assign s = a + (b ^ {W{sub}}) + W'(sub);

endmodule

// File: rtl/multiplicador_secuencial.sv
// Sequential multiplier: one add/shift iteration per clock, unsigned or Booth,
// with a built-in start/busy/done controller.
module multiplicador_secuencial
   import mult_pkg::*;
#(
   parameter int BITS = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              signed_mode,
   input  logic [BITS-1:0]   DP_B,
   input  logic [BITS-1:0]   DP_Q,
   output logic [2*BITS-1:0] Producto,
   output logic              busy,
   output logic              done
);

   localparam int W  = BITS + 1;
   localparam int PW = $clog2(BITS + 1);

   state_t          state;
   logic [W-1:0]    a;
   logic [W-1:0]    b;
   logic [BITS-1:0] q;
   logic            q_1;
   logic            mode;
   logic [PW-1:0]   p;

   logic [1:0]      op;
   logic            sub_sel;
   logic [W-1:0]    sum;
   logic [W-1:0]    a_sel;
   logic            fill;
   logic [W-1:0]    a_nxt;
   logic [BITS-1:0] q_nxt;

   assign op      = booth_op(mode, q[0], q_1);
   assign sub_sel = (op == BOOTH_SUB);

   sumador_restador #(.W(W)) u_addsub (
      .a   (a),
      .b   (b),
      .sub (sub_sel),
      .s   (sum)
   );

   // One iteration: optional add/sub, then a right shift of {A,Q}; signed
   // mode replicates the guard bit, unsigned mode shifts in zero.
   always_comb begin
      a_sel = (op == BOOTH_NOP) ? a : sum;
      fill  = mode & a_sel[BITS];
      a_nxt = {fill, a_sel[BITS:1]};
      q_nxt = {a_sel[0], q[BITS-1:1]};
   end

   // Controller and datapath registers; outputs are registered alongside state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         a        <= '0;
         b        <= '0;
         q        <= '0;
         q_1      <= 1'b0;
         mode     <= 1'b0;
         p        <= '0;
         Producto <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a     <= '0;
                  b     <= signed_mode ? {DP_B[BITS-1], DP_B} : {1'b0, DP_B};
                  q     <= DP_Q;
                  q_1   <= 1'b0;
                  mode  <= signed_mode;
                  p     <= PW'(BITS);
                  busy  <= 1'b1;
                  state <= CALC;
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               a   <= a_nxt;
               q   <= q_nxt;
               q_1 <= q[0];
               p   <= p - PW'(1);
               if (p == PW'(1)) begin
                  Producto <= {a_nxt[BITS-1:0], q_nxt};
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Directed self-checking bench for multiplicador_secuencial at BITS=8.
module tb_multiplicador_secuencial;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        signed_mode;
   logic [7:0]  DP_B;
   logic [7:0]  DP_Q;
   logic [15:0] Producto;
   logic        busy;
   logic        done;

   int tests = 0;
   int fails = 0;

   multiplicador_secuencial #(.BITS(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .signed_mode (signed_mode),
      .DP_B        (DP_B),
      .DP_Q        (DP_Q),
      .Producto    (Producto),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic run_op(input logic [7:0] b_op, input logic [7:0] q_op,
                         input logic m, input logic [15:0] exp, input string nm);
      int lat;
      int bcnt;
      @(negedge clk);
      DP_B = b_op; DP_Q = q_op; signed_mode = m; start = 1'b1;
      @(negedge clk);
      start = 1'b0; lat = 1; bcnt = 0;
      while (!done && lat < 20) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      tests++;
      if (lat !== 9) begin
         fails++; $display("FAIL %s latency: got %0d want 9", nm, lat);
      end
      tests++;
      if (bcnt !== 8) begin
         fails++; $display("FAIL %s busy_cycles: got %0d want 8", nm, bcnt);
      end
      tests++;
      if (Producto !== exp) begin
         fails++; $display("FAIL %s product: got %h want %h", nm, Producto, exp);
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || Producto !== exp) begin
         fails++; $display("FAIL %s hold: done=%b prod=%h want done=0 prod=%h", nm, done, Producto, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; signed_mode = 1'b0; DP_B = '0; DP_Q = '0;
      repeat (2) @(negedge clk);
      tests++;
      if ({Producto, busy, done} !== 18'd0) begin
         fails++; $display("FAIL reset_state: got prod=%h busy=%b done=%b want 0", Producto, busy, done);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_unsigned();
      run_op(8'd255, 8'd255, 1'b0, 16'hFE01, "u255x255");
      run_op(8'd0,   8'd200, 1'b0, 16'h0000, "u0x200");
      run_op(8'd1,   8'd173, 1'b0, 16'h00AD, "u1x173");
   endtask

   task automatic test_signed();
      run_op(8'hFD, 8'd5,   1'b1, 16'hFFF1, "s-3x5");
      run_op(8'h80, 8'h80,  1'b1, 16'h4000, "s-128x-128");
      run_op(8'h7F, 8'h80,  1'b1, 16'hC080, "s127x-128");
      run_op(8'd0,  8'd200, 1'b1, 16'h0000, "s0x200");
      run_op(8'd1,  8'd173, 1'b1, 16'hFFAD, "s1x-83");
   endtask

   task automatic test_ignore_start();
      int lat;
      @(negedge clk);
      DP_B = 8'd3; DP_Q = 8'd4; signed_mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; lat = 1;
      while (!done && lat < 20) begin
         if (lat == 3) begin
            DP_B = 8'd9; DP_Q = 8'd9; signed_mode = 1'b1; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      tests++;
      if (lat !== 9) begin
         fails++; $display("FAIL ignore_latency: got %0d want 9", lat);
      end
      tests++;
      if (Producto !== 16'h000C) begin
         fails++; $display("FAIL ignore_product: got %h want 000c", Producto);
      end
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         fails++; $display("FAIL ignore_idle: busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      int gap;
      @(negedge clk);
      DP_B = 8'd6; DP_Q = 8'd7; signed_mode = 1'b0; start = 1'b1;
      @(negedge clk);
      lat = 1;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      tests++;
      if (lat !== 9 || Producto !== 16'h002A) begin
         fails++; $display("FAIL b2b_first: lat=%0d prod=%h want 9 002a", lat, Producto);
      end
      DP_B = 8'd200; DP_Q = 8'd3;
      @(negedge clk);
      start = 1'b0; gap = 1;
      while (!done && gap < 20) begin
         @(negedge clk);
         gap++;
      end
      tests++;
      if (gap !== 9 || Producto !== 16'h0258) begin
         fails++; $display("FAIL b2b_second: gap=%0d prod=%h want 9 0258", gap, Producto);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int cyc;
      @(negedge clk);
      DP_B = 8'd100; DP_Q = 8'd100; signed_mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (cyc = 1; cyc < 4; cyc++) @(negedge clk);
      rst = 1'b1;
      #1;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || Producto !== 16'h0000) begin
         fails++; $display("FAIL reset_mid: busy=%b done=%b prod=%h want 0 0 0000", busy, done, Producto);
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL reset_hold: busy=%b done=%b want 0 0", busy, done);
      end
      rst = 1'b0;
      run_op(8'd7, 8'd6, 1'b0, 16'h002A, "after_rst_7x6");
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
